// File: rtl/ptcalc_mul_pipe_if.sv
// rtl/ptcalc_mul_pipe_if.sv - handshake bundle for the pT pipelined multiplier
// Ports (signals):
//   in_valid/in_ready   input-side handshake
//   din0 [A_WIDTH], din1 [B_WIDTH]   operands
//   out_valid/out_ready output-side handshake
//   dout [P_WIDTH], ovf  scaled product and overflow sideband
// Modports: master = producer/consumer side, slave = multiplier side.
interface ptcalc_mul_pipe_if #(
  parameter int A_WIDTH = 22,
  parameter int B_WIDTH = 7,
  parameter int P_WIDTH = 29
);
  logic               in_valid;
  logic               in_ready;
  logic [A_WIDTH-1:0] din0;
  logic [B_WIDTH-1:0] din1;
  logic               out_valid;
  logic               out_ready;
  logic [P_WIDTH-1:0] dout;
  logic               ovf;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, ovf
  );
endinterface

// File: rtl/ptcalc_mul_pipe.sv
// rtl/ptcalc_mul_pipe.sv - pipelined signed/unsigned multiplier with scale, round and saturate
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, overrides ce
//   ce     clock enable; low freezes every register
//   bus    ptcalc_mul_pipe_if.slave: in_valid/in_ready/din0/din1 in,
//          out_valid/out_ready/dout/ovf out
module ptcalc_mul_pipe #(
  parameter int A_WIDTH  = 22,
  parameter int B_WIDTH  = 7,
  parameter int A_SIGNED = 1,
  parameter int B_SIGNED = 0,
  parameter int P_WIDTH  = 29,
  parameter int SHIFT    = 0,
  parameter int ROUND    = 0,
  parameter int SATURATE = 0,
  parameter int STAGES   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  ptcalc_mul_pipe_if.slave bus
);

  // Full exact product width after one-bit extension of each operand.
  localparam int PF = A_WIDTH + B_WIDTH + 1;
  localparam bit RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

  // Scaling works one bit wider than PF so the rounding add cannot wrap
  // (unsigned x unsigned products come close to the top of PF).
  localparam logic [PF:0] ONE = {{PF{1'b0}}, 1'b1};
  localparam logic signed [PF:0] RND_ADD =
    ((ROUND != 0) && (SHIFT > 0)) ? ((ONE << SHIFT) >> 1) : '0;
  localparam logic signed [PF:0] HI =
    RES_SIGNED ? ((ONE << (P_WIDTH - 1)) - ONE) : ((ONE << P_WIDTH) - ONE);
  localparam logic signed [PF:0] LO =
    RES_SIGNED ? -(ONE << (P_WIDTH - 1)) : '0;

  logic [A_WIDTH:0]      a_ext;
  logic [B_WIDTH:0]      b_ext;
  logic signed [PF-1:0]  a_pf;
  logic signed [PF-1:0]  b_pf;
  logic signed [PF-1:0]  prod_in;
  logic signed [PF-1:0]  final_p;
  logic signed [PF:0]    rs;
  logic signed [PF:0]    s;
  logic [P_WIDTH-1:0]    dout_d;
  logic                  ovf_d;
  logic [STAGES-1:0]     v_q;
  logic [P_WIDTH-1:0]    dout_q;
  logic                  ovf_q;
  logic                  advance;

  assign advance      = ce & (~v_q[STAGES-1] | bus.out_ready);
  assign bus.in_ready = advance;

  // Operand extension: sign bit replicated for two's complement, zero otherwise.
  assign a_ext = (A_SIGNED != 0) ? {bus.din0[A_WIDTH-1], bus.din0} : {1'b0, bus.din0};
  assign b_ext = (B_SIGNED != 0) ? {bus.din1[B_WIDTH-1], bus.din1} : {1'b0, bus.din1};
  assign a_pf  = {{(PF - A_WIDTH - 1){a_ext[A_WIDTH]}}, a_ext};
  assign b_pf  = {{(PF - B_WIDTH - 1){b_ext[B_WIDTH]}}, b_ext};
  assign prod_in = a_pf * b_pf;

  // Multiply happens ahead of stage 1; the product then rides the data
  // stages and scale/saturate sits in front of the output register.
  generate
    if (STAGES > 1) begin : g_pipe
      logic signed [PF-1:0] pr_q [STAGES-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < STAGES - 1; i++) pr_q[i] <= '0;
        end else if (advance) begin
          pr_q[0] <= prod_in;
          for (int i = 1; i < STAGES - 1; i++) pr_q[i] <= pr_q[i-1];
        end
      end

      assign final_p = pr_q[STAGES-2];
    end else begin : g_direct
      assign final_p = prod_in;
    end
  endgenerate

  // Round half up, then arithmetic shift.
  assign rs = {final_p[PF-1], final_p} + RND_ADD;
  assign s  = rs >>> SHIFT;

  always_comb begin
    ovf_d  = (s > HI) || (s < LO);
    dout_d = s[P_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (s > HI) dout_d = HI[P_WIDTH-1:0];
      else if (s < LO) dout_d = LO[P_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      v_q[0] <= bus.in_valid;
      for (int i = 1; i < STAGES; i++) v_q[i] <= v_q[i-1];
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.dout      = dout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_ptcalc_mul_pipe.sv
// tb/tb_ptcalc_mul_pipe.sv - scoreboard bench for ptcalc_mul_pipe over several configurations
module tb_ptcalc_mul_pipe;

  localparam int N = 5;
  localparam int AS_T  [N] = '{1, 1, 1, 1, 0};
  localparam int BS_T  [N] = '{0, 0, 0, 0, 0};
  localparam int PW_T  [N] = '{29, 16, 16, 29, 8};
  localparam int SH_T  [N] = '{0, 0, 0, 4, 2};
  localparam int RD_T  [N] = '{0, 0, 0, 1, 0};
  localparam int SAT_T [N] = '{0, 1, 0, 0, 1};
  localparam int ST_T  [N] = '{3, 4, 3, 2, 1};

  typedef struct packed {
    logic [28:0] d;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ce;
  logic        in_valid_a  [N];
  logic [21:0] din0_a      [N];
  logic [6:0]  din1_a      [N];
  logic        out_ready_a [N];
  wire         in_ready_w  [N];
  wire         out_valid_w [N];
  wire  [28:0] dout_w      [N];
  wire         ovf_w       [N];

  int   vectors = 0;
  int   miscompares = 0;
  int   n_acc = 0;
  int   n_out = 0;
  exp_t sb[$];
  exp_t pend;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ptcalc_mul_pipe_if #(.A_WIDTH(22), .B_WIDTH(7), .P_WIDTH(PW_T[g])) ifc ();

    assign ifc.in_valid   = in_valid_a[g];
    assign ifc.din0       = din0_a[g];
    assign ifc.din1       = din1_a[g];
    assign ifc.out_ready  = out_ready_a[g];
    assign in_ready_w[g]  = ifc.in_ready;
    assign out_valid_w[g] = ifc.out_valid;
    assign dout_w[g]      = 29'(ifc.dout);
    assign ovf_w[g]       = ifc.ovf;

    ptcalc_mul_pipe #(
      .A_WIDTH(22), .B_WIDTH(7), .A_SIGNED(AS_T[g]), .B_SIGNED(BS_T[g]),
      .P_WIDTH(PW_T[g]), .SHIFT(SH_T[g]), .ROUND(RD_T[g]),
      .SATURATE(SAT_T[g]), .STAGES(ST_T[g])
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .bus   (ifc)
    );
  end

  // Reference arithmetic on 64-bit integers.
  function automatic exp_t model(int i, logic [21:0] a, logic [6:0] b);
    longint av, bv, p, s, hi, lo, r;
    exp_t e;
    av = (AS_T[i] != 0) ? longint'($signed(a)) : longint'(a);
    bv = (BS_T[i] != 0) ? longint'($signed(b)) : longint'(b);
    p = av * bv;
    if (RD_T[i] != 0 && SH_T[i] > 0) p = p + (longint'(1) << (SH_T[i] - 1));
    s = p >>> SH_T[i];
    if (AS_T[i] != 0 || BS_T[i] != 0) begin
      hi = (longint'(1) << (PW_T[i] - 1)) - 1;
      lo = -(longint'(1) << (PW_T[i] - 1));
    end else begin
      hi = (longint'(1) << PW_T[i]) - 1;
      lo = 0;
    end
    e.o = (s > hi) || (s < lo);
    r = s;
    if (SAT_T[i] != 0) begin
      if (s > hi) r = hi;
      else if (s < lo) r = lo;
    end
    e.d = 29'(r & ((longint'(1) << PW_T[i]) - 1));
    return e;
  endfunction

  function automatic logic [21:0] rand_a();
    case ($urandom_range(0, 4))
      0: return 22'h1FFFFF;
      1: return 22'h200000;
      2: return 22'h3FFFFF;
      3: return 22'($urandom_range(0, 255));
      default: return 22'($urandom);
    endcase
  endfunction

  function automatic logic [6:0] rand_b();
    case ($urandom_range(0, 3))
      0: return 7'h7F;
      1: return 7'h40;
      2: return 7'h00;
      default: return 7'($urandom);
    endcase
  endfunction

  task automatic set_in(int i, bit v, logic [21:0] a, logic [6:0] b);
    in_valid_a[i] = v;
    din0_a[i] = a;
    din1_a[i] = b;
    pend = model(i, a, b);
  endtask

  task automatic set_in_exp(int i, logic [21:0] a, logic [6:0] b, logic [28:0] d, logic o);
    in_valid_a[i] = 1'b1;
    din0_a[i] = a;
    din1_a[i] = b;
    pend.d = d;
    pend.o = o;
  endtask

  // One clock: score the output handshake, record the input handshake, advance.
  task automatic cycle(int i);
    exp_t e;
    #1;
    if (!reset && out_valid_w[i] && out_ready_a[i] && ce) begin
      vectors++;
      n_out++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL dut%0d extra_output: dout=%h ovf=%b, nothing expected", i, dout_w[i], ovf_w[i]);
      end else begin
        e = sb.pop_front();
        if (dout_w[i] !== e.d || ovf_w[i] !== e.o) begin
          miscompares++;
          $display("FAIL dut%0d result: dout=%h ovf=%b, expected dout=%h ovf=%b",
                   i, dout_w[i], ovf_w[i], e.d, e.o);
        end
      end
    end else if (!reset && out_valid_w[i] && sb.size() != 0) begin
      vectors++;
      if (dout_w[i] !== sb[0].d || ovf_w[i] !== sb[0].o) begin
        miscompares++;
        $display("FAIL dut%0d hold: dout=%h ovf=%b, expected dout=%h ovf=%b",
                 i, dout_w[i], ovf_w[i], sb[0].d, sb[0].o);
      end
    end
    if (!reset && in_valid_a[i] && in_ready_w[i]) begin
      sb.push_back(pend);
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int i, int budget);
    int n = 0;
    in_valid_a[i] = 1'b0;
    out_ready_a[i] = 1'b1;
    ce = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      cycle(i);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL dut%0d drain_timeout: %0d results outstanding, expected 0", i, sb.size());
      sb.delete();
    end
  endtask

  // One sample with exact latency check: out_valid low until STAGES edges.
  task automatic latency_single(int i, logic [21:0] a, logic [6:0] b, logic [28:0] d, logic o);
    int m;
    out_ready_a[i] = 1'b1;
    set_in_exp(i, a, b, d, o);
    cycle(i);
    in_valid_a[i] = 1'b0;
    m = 1;
    while (m < ST_T[i]) begin
      vectors++;
      if (out_valid_w[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL dut%0d early_valid: out_valid=%b after %0d edges, expected 0", i, out_valid_w[i], m);
      end
      cycle(i);
      m++;
    end
    vectors++;
    if (out_valid_w[i] !== 1'b1) begin
      miscompares++;
      $display("FAIL dut%0d latency: out_valid=%b after %0d edges, expected 1", i, out_valid_w[i], m);
    end
    drain(i, 10);
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (out_valid_w[i] !== 1'b0 || dout_w[i] !== 29'd0 || ovf_w[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL dut%0d reset_state: out_valid=%b dout=%h ovf=%b, expected 0/0/0",
                 i, out_valid_w[i], dout_w[i], ovf_w[i]);
      end
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready_w[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL dut0 idle_ready: in_ready=%b, expected 1", in_ready_w[0]);
    end
  endtask

  task automatic test_defaults();
    latency_single(0, 22'h3FFFFF, 7'd127, 29'h1FFFFF81, 1'b0);
    latency_single(0, 22'h1FFFFF, 7'd127, 29'd266338177, 1'b0);
  endtask

  task automatic test_saturate();
    latency_single(1, 22'h1FFFFF, 7'd127, 29'h7FFF, 1'b1);
    latency_single(1, 22'h200000, 7'd127, 29'h8000, 1'b1);
    latency_single(2, 22'h1FFFFF, 7'd127, 29'hFF81, 1'b1);
    latency_single(2, 22'h200000, 7'd127, 29'h0000, 1'b1);
  endtask

  task automatic test_round();
    latency_single(3, 22'h3FFFE8, 7'd1, 29'h1FFFFFFF, 1'b0);
    latency_single(3, 22'h3FFFE7, 7'd1, 29'h1FFFFFFE, 1'b0);
    latency_single(3, 22'd24, 7'd1, 29'd2, 1'b0);
    latency_single(3, 22'd23, 7'd1, 29'd1, 1'b0);
  endtask

  task automatic test_back_to_back();
    n_acc = 0;
    n_out = 0;
    for (int c = 0; c < 80 && n_out < 10; c++) begin
      out_ready_a[0] = !(c >= 5 && c < 10);
      if (n_acc < 10) set_in(0, 1'b1, 22'(n_acc * 40503 - 200000), 7'(n_acc * 13 + 5));
      else in_valid_a[0] = 1'b0;
      #1;
      if (c >= 5 && c < 10) begin
        vectors++;
        if (out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL dut0 stall_ready: out_valid=%b in_ready=%b, expected 1/0",
                   out_valid_w[0], in_ready_w[0]);
        end
      end
      cycle(0);
    end
    vectors++;
    if (n_acc !== 10 || n_out !== 10 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL dut0 stream_count: accepted=%0d delivered=%0d pending=%0d, expected 10/10/0",
               n_acc, n_out, sb.size());
    end
    drain(0, 10);
  endtask

  task automatic test_ce();
    int m;
    out_ready_a[0] = 1'b1;
    set_in(0, 1'b1, 22'h2ABCDE, 7'h55);
    cycle(0);
    in_valid_a[0] = 1'b0;
    m = 1;
    while (m < ST_T[0] + 3) begin
      ce = (m >= 2 && m <= 4) ? 1'b0 : 1'b1;
      #1;
      vectors++;
      if (out_valid_w[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL dut0 ce_early_valid: out_valid=%b after %0d edges, expected 0", out_valid_w[0], m);
      end
      if (!ce) begin
        vectors++;
        if (in_ready_w[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL dut0 ce_ready: in_ready=%b with ce low, expected 0", in_ready_w[0]);
        end
      end
      cycle(0);
      m++;
    end
    ce = 1'b1;
    vectors++;
    if (out_valid_w[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL dut0 ce_latency: out_valid=%b after %0d edges, expected 1", out_valid_w[0], m);
    end
    drain(0, 10);
  endtask

  task automatic test_random();
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < 40; c++) begin
        ce = ($urandom_range(0, 99) < 85);
        out_ready_a[i] = ($urandom_range(0, 99) < 70);
        set_in(i, ($urandom_range(0, 99) < 75), rand_a(), rand_b());
        cycle(i);
      end
      drain(i, 50);
    end
  endtask

  task automatic test_reset_flush();
    exp_t e;
    out_ready_a[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1'b1, 22'(k * 1000 + 77), 7'(k + 9));
      cycle(0);
    end
    in_valid_a[0] = 1'b0;
    reset = 1'b1;
    cycle(0);
    reset = 1'b0;
    vectors++;
    if (out_valid_w[0] !== 1'b0 || dout_w[0] !== 29'd0 || ovf_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL dut0 flush_state: out_valid=%b dout=%h ovf=%b, expected 0/0/0",
               out_valid_w[0], dout_w[0], ovf_w[0]);
    end
    sb.delete();
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (out_valid_w[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL dut0 flushed_sample: out_valid=%b %0d edges after reset, expected 0", out_valid_w[0], k);
      end
      cycle(0);
    end
    e = model(0, 22'h0F0F0F, 7'h3C);
    latency_single(0, 22'h0F0F0F, 7'h3C, e.d, e.o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ce = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid_a[i] = 1'b0;
      din0_a[i] = '0;
      din1_a[i] = '0;
      out_ready_a[i] = 1'b1;
    end
    pend = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_defaults();
    test_saturate();
    test_round();
    test_back_to_back();
    test_ce();
    test_random();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
